// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared divider width, limits and period detector state type
package synth_pkg;

    localparam int DIV_W = 19;
    localparam logic [DIV_W-1:0] DIV_MAX = 19'h7FFFF;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } pd_state_t;

endpackage

// File: rtl/pulse_edge_detect.sv
// rtl/pulse_edge_detect.sv - optional input synchronizer and rising-edge detector
module pulse_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic rise
);

    logic sync;
    logic sync_d_q;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync = pulse_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= pulse_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign sync = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d_q <= 1'b0;
        end else begin
            sync_d_q <= sync;
        end
    end

    assign rise = sync & ~sync_d_q;

endmodule

// File: rtl/period_detector.sv
// rtl/period_detector.sv - measures rise-to-rise spacing of a pulse train as a divider value
module period_detector
    import synth_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    // Counter value at which a missing edge is declared; default is the full divider range.
    parameter logic [DIV_W-1:0] TIMEOUT_CNT = DIV_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [DIV_W-1:0] divider_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    logic             rise;
    pd_state_t        state_q, state_d;
    logic [DIV_W-1:0] counter_q, counter_d;
    logic [DIV_W-1:0] last_meas_q, last_meas_d;
    logic             have_meas_q, have_meas_d;
    logic [DIV_W-1:0] divider_q, divider_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    pulse_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .rise     (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            counter_q   <= '0;
            last_meas_q <= '0;
            have_meas_q <= 1'b0;
            divider_q   <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            last_meas_q <= last_meas_d;
            have_meas_q <= have_meas_d;
            divider_q   <= divider_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        last_meas_d = last_meas_q;
        have_meas_d = have_meas_q;
        divider_d   = divider_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;

        if (!enable) begin
            state_d     = IDLE;
            counter_d   = '0;
            have_meas_d = 1'b0;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    counter_d = '0;
                    state_d   = ARM;
                end
                ARM: begin
                    counter_d = '0;
                    if (rise) begin
                        state_d     = MEASURE;
                        have_meas_d = 1'b0;
                    end
                end
                MEASURE: begin
                    // A rise on the terminal count still counts as a measurement.
                    if (rise) begin
                        divider_d   = counter_q;
                        valid_d     = 1'b1;
                        counter_d   = '0;
                        last_meas_d = counter_q;
                        locked_d    = have_meas_q && (counter_q == last_meas_q);
                        have_meas_d = 1'b1;
                        timeout_d   = 1'b0;
                    end else if (counter_q == TIMEOUT_CNT) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        counter_d = '0;
                        state_d   = ARM;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    counter_d = '0;
                end
            endcase
        end
    end

    assign divider_out = divider_q;
    assign meas_valid  = valid_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_period_detector.sv
// tb/tb_period_detector.sv - directed self-checking bench for period_detector
module tb_period_detector;

    localparam logic [18:0] TO_CNT = 19'd1023;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pulse_in;
    logic [18:0] divider_out;
    logic        meas_valid;
    logic        locked;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    int q_val[$];
    bit q_lock[$];
    int q_cyc[$];
    int cyc     = 0;
    int to_cyc  = 0;
    bit to_seen = 0;
    bit to_prev = 0;

    period_detector #(
        .SYNC_STAGES (2),
        .TIMEOUT_CNT (TO_CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .divider_out (divider_out),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (meas_valid) begin
            q_val.push_back(int'(divider_out));
            q_lock.push_back(locked);
            q_cyc.push_back(cyc);
        end
        if (timeout && !to_prev && !to_seen) begin
            to_cyc  = cyc;
            to_seen = 1'b1;
        end
        to_prev = timeout;
    end

    task automatic clear_log();
        q_val.delete();
        q_lock.delete();
        q_cyc.delete();
        to_seen = 1'b0;
    endtask

    task automatic drive_train(input int period, input int pulses);
        for (int p = 0; p < pulses; p++) begin
            @(negedge clk) pulse_in = 1'b1;
            for (int c = 1; c < period; c++) begin
                @(negedge clk) pulse_in = 1'b0;
            end
        end
    endtask

    task automatic restart();
        @(negedge clk) enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; pulse_in = 1'b0;
        #23;
        total++; if (divider_out !== 19'd0) begin bad++; $display("FAIL reset_div got=%0d want=0", divider_out); end
        total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", meas_valid); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loop99();
        restart();
        drive_train(100, 4);
        repeat (6) @(negedge clk);
        total++; if (q_val.size() !== 3) begin bad++; $display("FAIL d99_count got=%0d want=3", q_val.size()); end
        if (q_val.size() >= 3) begin
            total++; if (q_val[0] !== 99) begin bad++; $display("FAIL d99_first got=%0d want=99", q_val[0]); end
            total++; if (q_lock[0] !== 1'b0) begin bad++; $display("FAIL d99_first_lock got=%b want=0", q_lock[0]); end
            total++; if (q_val[1] !== 99) begin bad++; $display("FAIL d99_second got=%0d want=99", q_val[1]); end
            total++; if (q_lock[1] !== 1'b1) begin bad++; $display("FAIL d99_second_lock got=%b want=1", q_lock[1]); end
            total++; if (q_cyc[2] - q_cyc[1] !== 100) begin bad++; $display("FAIL d99_spacing got=%0d want=100", q_cyc[2] - q_cyc[1]); end
        end
    endtask

    task automatic test_div1();
        restart();
        drive_train(2, 6);
        repeat (6) @(negedge clk);
        total++; if (q_val.size() !== 5) begin bad++; $display("FAIL d1_count got=%0d want=5", q_val.size()); end
        if (q_val.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                total++; if (q_val[i] !== 1) begin bad++; $display("FAIL d1_val[%0d] got=%0d want=1", i, q_val[i]); end
            end
            total++; if (q_lock[0] !== 1'b0) begin bad++; $display("FAIL d1_lock0 got=%b want=0", q_lock[0]); end
            total++; if (q_lock[4] !== 1'b1) begin bad++; $display("FAIL d1_lock4 got=%b want=1", q_lock[4]); end
            total++; if (q_cyc[3] - q_cyc[2] !== 2) begin bad++; $display("FAIL d1_spacing got=%0d want=2", q_cyc[3] - q_cyc[2]); end
        end
    endtask

    task automatic test_change();
        restart();
        drive_train(51, 3);
        drive_train(81, 3);
        total++; if (q_val.size() !== 5) begin bad++; $display("FAIL chg_count got=%0d want=5", q_val.size()); end
        if (q_val.size() >= 5) begin
            total++; if (q_val[2] !== 50) begin bad++; $display("FAIL chg_old got=%0d want=50", q_val[2]); end
            total++; if (q_val[3] !== 80 || q_lock[3] !== 1'b0) begin bad++; $display("FAIL chg_new got=%0d/%b want=80/0", q_val[3], q_lock[3]); end
            total++; if (q_val[4] !== 80 || q_lock[4] !== 1'b1) begin bad++; $display("FAIL chg_relock got=%0d/%b want=80/1", q_val[4], q_lock[4]); end
        end
    endtask

    task automatic test_enable_drop();
        restart();
        total++; if (divider_out !== 19'd80) begin bad++; $display("FAIL en_hold got=%0d want=80", divider_out); end
        drive_train(500, 1);
        @(negedge clk) enable = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL en_idle_lock got=%b want=0", locked); end
        enable = 1'b1;
        repeat (500) @(negedge clk);
        total++; if (q_val.size() !== 0) begin bad++; $display("FAIL en_no_strobe got=%0d want=0", q_val.size()); end
        drive_train(1000, 2);
        total++; if (q_val.size() !== 1) begin bad++; $display("FAIL en_count got=%0d want=1", q_val.size()); end
        if (q_val.size() >= 1) begin
            total++; if (q_val[0] !== 999) begin bad++; $display("FAIL en_value got=%0d want=999", q_val[0]); end
        end
    endtask

    task automatic test_timeout();
        restart();
        drive_train(30, 3);
        @(negedge clk) pulse_in = 1'b1;
        repeat (1100) @(negedge clk);
        total++; if (q_val.size() !== 3) begin bad++; $display("FAIL to_count got=%0d want=3", q_val.size()); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_flag got=%b want=1", timeout); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL to_locked got=%b want=0", locked); end
        total++; if (divider_out !== 19'd29) begin bad++; $display("FAIL to_div_hold got=%0d want=29", divider_out); end
        if (q_val.size() >= 3) begin
            total++; if (!to_seen || (to_cyc - q_cyc[2]) !== 1024) begin bad++; $display("FAIL to_time got=%0d want=1024", to_cyc - q_cyc[2]); end
        end
        @(negedge clk) pulse_in = 1'b0;
        clear_log();
        drive_train(40, 2);
        total++; if (q_val.size() !== 1) begin bad++; $display("FAIL to_rearm_count got=%0d want=1", q_val.size()); end
        if (q_val.size() >= 1) begin
            total++; if (q_val[0] !== 39) begin bad++; $display("FAIL to_rearm_val got=%0d want=39", q_val[0]); end
        end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", timeout); end
    endtask

    task automatic test_boundary();
        restart();
        drive_train(1024, 3);
        total++; if (q_val.size() !== 2) begin bad++; $display("FAIL bnd_edge_count got=%0d want=2", q_val.size()); end
        if (q_val.size() >= 2) begin
            total++; if (q_val[1] !== 1023) begin bad++; $display("FAIL bnd_edge_val got=%0d want=1023", q_val[1]); end
        end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL bnd_edge_to got=%b want=0", timeout); end
        restart();
        drive_train(1025, 3);
        total++; if (q_val.size() !== 0) begin bad++; $display("FAIL bnd_over_count got=%0d want=0", q_val.size()); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL bnd_over_to got=%b want=1", timeout); end
    endtask

    task automatic test_async_reset();
        restart();
        drive_train(20, 3);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL ar_prelock got=%b want=1", locked); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (divider_out !== 19'd0) begin bad++; $display("FAIL ar_div got=%0d want=0", divider_out); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL ar_locked got=%b want=0", locked); end
        total++; if (timeout !== 1'b0 || meas_valid !== 1'b0) begin bad++; $display("FAIL ar_flags got=%b%b want=00", timeout, meas_valid); end
        @(negedge clk) rst_n = 1'b1;
        clear_log();
        drive_train(20, 1);
        total++; if (q_val.size() !== 0) begin bad++; $display("FAIL ar_first_rise got=%0d want=0", q_val.size()); end
        drive_train(20, 1);
        total++; if (q_val.size() !== 1) begin bad++; $display("FAIL ar_count got=%0d want=1", q_val.size()); end
        if (q_val.size() >= 1) begin
            total++; if (q_val[0] !== 19 || q_lock[0] !== 1'b0) begin bad++; $display("FAIL ar_value got=%0d/%b want=19/0", q_val[0], q_lock[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_loop99();
        test_div1();
        test_change();
        test_enable_drop();
        test_timeout();
        test_boundary();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
